// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing init sequencer, clear request and write-conflict flag.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     ready,
  input  logic [NUM_RD*IDX_W-1:0]  rdNum,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  input  logic [NUM_WR-1:0]        wrEnable,
  input  logic [NUM_WR*IDX_W-1:0]  wrNum,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  output logic                     wrConflict
);

  localparam logic       CLEAR   = 1'b0;
  localparam logic       RUN     = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam bit         ZR      = (ZERO_REG != 0);

  logic                 state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 conflict_q, conflict_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [NUM_WR-1:0]    wr_ok;

  // A port write is effective only in RUN and when it does not target the hard-wired zero entry.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wrEnable[j] && (state_q == RUN) &&
                 !(ZR && (wrNum[j*IDX_W +: IDX_W] == '0));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = RUN;
      end
    end else if (clr) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (wr_ok[j] && wr_ok[k] &&
            (wrNum[j*IDX_W +: IDX_W] == wrNum[k*IDX_W +: IDX_W])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage has no reset so it can map to RAM; later ports override earlier ones on a shared entry.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          mem_q[wrNum[j*IDX_W +: IDX_W]] <= wrData[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((state_q == RUN) && !(ZR && (rdNum[i*IDX_W +: IDX_W] == '0))) begin
        rdData[i*DATA_W +: DATA_W] = mem_q[rdNum[i*IDX_W +: IDX_W]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && (wrNum[j*IDX_W +: IDX_W] == rdNum[i*IDX_W +: IDX_W])) begin
            rdData[i*DATA_W +: DATA_W] = wrData[j*DATA_W +: DATA_W];
          end
        end
`else
`endif
      end
    end
  end

  assign ready      = (state_q == RUN);
  assign wrConflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: 32x32, two read ports, two write ports, zero register on.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int DP = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          ready;
  logic [2*IW-1:0] rdNum;
  logic [2*DW-1:0] rdData;
  logic [1:0]      wrEnable;
  logic [2*IW-1:0] wrNum;
  logic [2*DW-1:0] wrData;
  logic            wrConflict;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edges;

  regfile_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
    .rdNum(rdNum), .rdData(rdData),
    .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData),
    .wrConflict(wrConflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ready is seen; a stuck sequencer ends at the bound.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic set_rd(input int a, input int b);
    rdNum = {IW'(b), IW'(a)};
  endtask

  task automatic set_wr(input logic [1:0] en, input int n0, input logic [31:0] d0,
                        input int n1, input logic [31:0] d1);
    wrEnable = en;
    wrNum    = {IW'(n1), IW'(n0)};
    wrData   = {d1, d0};
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    set_rd(0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_conflict", {31'd0, wrConflict}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Writes presented during the initial clear must be ignored.
    set_wr(2'b11, 9, 32'hAAAA_0000, 10, 32'hBBBB_0000);
    set_rd(9, 10);
    #1;
    chk("clear_rd0", rdData[31:0], 32'd0);
    wait_ready(n_edges);
    chk("init_ready_latency", n_edges, DP);
    set_wr(2'b00, 0, 0, 0, 0);

    for (int i = 0; i < DP; i++) begin
      set_rd(i, DP - 1 - i);
      #1;
      chk($sformatf("init_p0_r%0d", i), rdData[31:0], 32'd0);
      chk($sformatf("init_p1_r%0d", DP - 1 - i), rdData[63:32], 32'd0);
    end

    // Single write with same-cycle read of the target.
    set_wr(2'b01, 5, 32'hDEAD_BEEF, 0, 0);
    set_rd(5, 5);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("r5_same_cycle", rdData[31:0], 32'hDEAD_BEEF);
`else
    chk("r5_same_cycle", rdData[31:0], 32'd0);
`endif
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    chk("r5_next_p0", rdData[31:0], 32'hDEAD_BEEF);
    chk("r5_next_p1", rdData[63:32], 32'hDEAD_BEEF);
    chk("r5_no_conflict", {31'd0, wrConflict}, 32'd0);

    // Both ports write r0: dropped, and no conflict.
    set_wr(2'b11, 0, 32'h1234, 0, 32'h5678);
    set_rd(0, 5);
    #1;
    chk("r0_same_cycle", rdData[31:0], 32'd0);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    chk("r0_after", rdData[31:0], 32'd0);
    chk("r0_conflict", {31'd0, wrConflict}, 32'd0);
    chk("r5_kept", rdData[63:32], 32'hDEAD_BEEF);

    // Distinct targets on the two write ports.
    set_wr(2'b11, 8, 32'hAA, 9, 32'hBB);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(8, 9);
    #1;
    chk("r8", rdData[31:0], 32'hAA);
    chk("r9", rdData[63:32], 32'hBB);
    chk("r8r9_conflict", {31'd0, wrConflict}, 32'd0);

    // Same-entry write: port 1 wins, flag for exactly one cycle.
    set_wr(2'b11, 7, 32'h11, 7, 32'h22);
    set_rd(7, 8);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("r7_same_cycle", rdData[31:0], 32'h22);
`else
    chk("r7_same_cycle", rdData[31:0], 32'd0);
`endif
    chk("r7_conflict_before", {31'd0, wrConflict}, 32'd0);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    chk("r7_value", rdData[31:0], 32'h22);
    chk("r7_conflict_set", {31'd0, wrConflict}, 32'd1);
    step();
    chk("r7_conflict_clear", {31'd0, wrConflict}, 32'd0);

    // Clear request: the same-cycle write to r4 lands, then gets wiped.
    set_wr(2'b01, 3, 32'h55, 0, 0);
    step();
    clr = 1'b1;
    set_wr(2'b01, 4, 32'h66, 0, 0);
    set_rd(3, 4);
    #1;
    chk("r3_before_clr", rdData[31:0], 32'h55);
    step();
    clr = 1'b0;
    set_wr(2'b11, 3, 32'h99, 4, 32'h77);
    #1;
    chk("clr_ready_low", {31'd0, ready}, 32'd0);
    chk("clr_rd_zero", rdData[31:0], 32'd0);
    wait_ready(n_edges);
    chk("clr_ready_latency", n_edges, DP);
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    chk("r3_after_clr", rdData[31:0], 32'd0);
    chk("r4_after_clr", rdData[63:32], 32'd0);

    // Asynchronous reset drops a pending conflict flag immediately.
    set_wr(2'b11, 12, 32'h1, 12, 32'h2);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    chk("pre_rst_conflict", {31'd0, wrConflict}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_conflict", {31'd0, wrConflict}, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Reset again partway through the clear sequence (cnt=10).
    for (int i = 0; i < 10; i++) step();
    chk("mid_clear_ready", {31'd0, ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_conflict", {31'd0, wrConflict}, 32'd0);
    #1;
    rst_n = 1'b1;
    wait_ready(n_edges);
    chk("restart_ready_latency", n_edges, DP);
    set_rd(12, 5);
    #1;
    chk("restart_r12", rdData[31:0], 32'd0);
    chk("restart_r5", rdData[63:32], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
